outer_loop_ctrl: RTL

// - Blitter outer-loop sequencer. It sits directly upstream of the loadable ripple-counter bits and drives their load and clock-enable intent.
// - Holds the outer pass count loaded from the CPU data bus and issues one inner-loop start per pass.
// - Consumes the inner counter's completion pulse, decrements the count, and flags zero and operation done to the blitter control.

---
 rtl/outer_pkg.sv | 13 +
 rtl/outer_down_cnt.sv | 45 ++++
 rtl/outer_loop_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/outer_pkg.sv
// Shared types and defaults for the blitter outer-loop sequencer.
package outer_pkg;

    localparam int OUTER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } outer_state_t;

endpackage : outer_pkg

// File: rtl/outer_down_cnt.sv
// WIDTH-bit synchronous loadable down counter with a registered zero flag.
// Load has priority over enable; decrement wraps modulo 2**WIDTH.
module outer_down_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             zero_d, zero_q;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - ONE;
        end
        zero_d = (cnt_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = zero_q;

endmodule : outer_down_cnt

// File: rtl/outer_loop_ctrl.sv
// Blitter outer-loop sequencer: issues one inner pass per count, decrements on
// each inner completion, and reports zero/done. All outputs are registered.
module outer_loop_ctrl
    import outer_pkg::*;
#(
    parameter int WIDTH = OUTER_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA,
    input  logic             LD_OUTER,
    input  logic             START,
    input  logic             STOP,
    input  logic             INNER_DONE,
    output logic             INNER_GO,
    output logic [WIDTH-1:0] OUTER_CNT,
    output logic             OUTER_ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    outer_state_t state_d, state_q;
    logic         go_d, go_q;
    logic         busy_d, busy_q;
    logic         done_d, done_q;
    logic         cnt_load;
    logic         cnt_dec;

    outer_down_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (cnt_load),
        .en       (cnt_dec),
        .load_val (DATA),
        .cnt      (OUTER_CNT),
        .zero     (OUTER_ZERO)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                // A load in IDLE is honoured even alongside STOP or START.
                cnt_load = LD_OUTER;
                if (START && !STOP) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                state_d = STOP ? IDLE : WAIT;
            end
            WAIT: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (INNER_DONE) begin
                    cnt_dec = 1'b1;
                    state_d = (OUTER_CNT == ONE) ? FIN : ARM;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they align with the state register.
        go_d   = (state_d == ARM);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign INNER_GO = go_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule : outer_loop_ctrl
